// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - fetch/load-store arbiter for the shared single-ported memory
// Optional busy-state watchdog enabled by defining ARB_TIMEOUT_EN.
module mips_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        fetch_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t      r_state;
    logic [3:0]  r_starve;
    logic        r_if_rvalid, r_d_rvalid, r_bus_err;
    logic [31:0] r_if_rdata, r_d_rdata;
    logic        r_mem_req, r_mem_we;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_be;

    logic        w_if_win, w_d_win, w_busy, w_done, w_abort;
    logic [31:0] w_rdata;

    assign w_busy   = (r_state != IDLE);
    assign w_if_win = !w_busy && if_req && (!d_req || (r_starve == 4'(STARVE_LIMIT)));
    assign w_d_win  = !w_busy && d_req && !w_if_win;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_wdog;

    assign w_abort = w_busy && !mem_ack && (r_wdog == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= 8'd0;
        end else if (!w_busy) begin
            r_wdog <= 8'd0;
        end else if (!w_done) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end
`else
    // Without the watchdog a BUSY state only ends on mem_ack.
    assign w_abort = (TIMEOUT_CYC < 0);
`endif

    assign w_done  = w_busy && (mem_ack || w_abort);
    assign w_rdata = w_abort ? 32'h0 : mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_starve    <= 4'd0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_d_rdata   <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'h0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_if_win) begin
                        r_state     <= BUSY_IF;
                        r_starve    <= 4'd0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr & 32'hFFFF_FFFC;
                        r_mem_wdata <= 32'h0;
                        r_mem_be    <= 4'hF;
                    end else if (w_d_win) begin
                        r_state     <= BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr & 32'hFFFF_FFFC;
                        r_mem_wdata <= d_wdata;
                        r_mem_be    <= d_we ? d_be : 4'hF;
                        if (if_req && (r_starve != 4'(STARVE_LIMIT))) begin
                            r_starve <= r_starve + 4'd1;
                        end
                    end
                end
                BUSY_IF: begin
                    if (w_done) begin
                        r_state     <= IDLE;
                        r_mem_req   <= 1'b0;
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= w_rdata;
                        r_bus_err   <= w_abort;
                    end
                end
                default: begin
                    if (w_done) begin
                        r_state    <= IDLE;
                        r_mem_req  <= 1'b0;
                        r_d_rvalid <= 1'b1;
                        r_bus_err  <= w_abort;
                        // Stores leave the load data register untouched.
                        if (!r_mem_we || w_abort) begin
                            r_d_rdata <= w_rdata;
                        end
                    end
                end
            endcase
        end
    end

    assign if_gnt      = w_if_win;
    assign d_gnt       = w_d_win;
    assign if_rvalid   = r_if_rvalid;
    assign d_rvalid    = r_d_rvalid;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign fetch_stall = if_req && !r_if_rvalid;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_be      = r_mem_be;
    assign bus_err     = r_bus_err;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed and randomized bench for mips_mem_arbiter
module tb_mips_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, fetch_stall, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, bus_err;
    logic [3:0]  mem_be;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_d_rdata;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .fetch_stall(fetch_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    task automatic test_reset();
        reset = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        @(negedge clk); @(negedge clk);
        n_chk++; if ({mem_req, mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, bus_err, fetch_stall} !== 13'h0)
            $display("FAIL reset_ctrl got=%0h exp=0", {mem_req, mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, bus_err, fetch_stall}); else n_pass++;
        n_chk++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0)
            $display("FAIL reset_data got=%0h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata}); else n_pass++;
        reset = 1'b1;
        exp_d_rdata = 32'h0;
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h0000_0104; #1;
        n_chk++; if ({if_gnt, d_gnt, fetch_stall, mem_req} !== 4'b1010) $display("FAIL sf_c0 got=%b exp=1010", {if_gnt, d_gnt, fetch_stall, mem_req}); else n_pass++;
        @(negedge clk); mem_ack = 1; mem_rdata = 32'h2408_0005; #1;
        n_chk++; if (mem_addr !== 32'h104 || mem_be !== 4'hF || mem_we !== 0 || mem_req !== 1)
            $display("FAIL sf_c1_mem got=%h/%h/%b exp=00000104/f/0", mem_addr, mem_be, mem_we); else n_pass++;
        n_chk++; if ({fetch_stall, if_gnt, if_rvalid} !== 3'b100) $display("FAIL sf_c1_ctl got=%b exp=100", {fetch_stall, if_gnt, if_rvalid}); else n_pass++;
        @(negedge clk); mem_ack = 0; if_addr = 32'h0000_0108; #1;
        n_chk++; if (if_rvalid !== 1 || if_rdata !== 32'h2408_0005) $display("FAIL sf_c2_rdata got=%b/%h exp=1/24080005", if_rvalid, if_rdata); else n_pass++;
        n_chk++; if ({fetch_stall, if_gnt} !== 2'b01) $display("FAIL sf_c2_stall_gnt got=%b exp=01", {fetch_stall, if_gnt}); else n_pass++;
        @(negedge clk); if_req = 0; mem_ack = 1; mem_rdata = 32'h8C09_0010; #1;
        n_chk++; if (mem_addr !== 32'h108) $display("FAIL sf_next_addr got=%h exp=00000108", mem_addr); else n_pass++;
        @(negedge clk); mem_ack = 0; #1;
        n_chk++; if (if_rvalid !== 1 || if_rdata !== 32'h8C09_0010) $display("FAIL sf_next_rdata got=%h exp=8c090010", if_rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h1003; #1;
        n_chk++; if ({if_gnt, d_gnt} !== 2'b01) $display("FAIL sim_gnt got=%b exp=01", {if_gnt, d_gnt}); else n_pass++;
        @(negedge clk); d_req = 0; mem_ack = 1; mem_rdata = 32'h1234_5678; #1;
        n_chk++; if (mem_addr !== 32'h1000 || mem_be !== 4'hF || mem_we !== 0) $display("FAIL sim_mem got=%h/%h/%b exp=00001000/f/0", mem_addr, mem_be, mem_we); else n_pass++;
        @(negedge clk); mem_ack = 0; #1;
        exp_d_rdata = 32'h1234_5678;
        n_chk++; if (d_rvalid !== 1 || d_rdata !== exp_d_rdata || if_gnt !== 1) $display("FAIL sim_rvalid_fetch got=%b/%h/%b exp=1/12345678/1", d_rvalid, d_rdata, if_gnt); else n_pass++;
        @(negedge clk); if_req = 0; mem_ack = 1; mem_rdata = 32'h0000_0001; #1;
        n_chk++; if (mem_addr !== 32'h200) $display("FAIL sim_fetch_addr got=%h exp=00000200", mem_addr); else n_pass++;
        @(negedge clk); mem_ack = 0; @(negedge clk);
    endtask

    task automatic test_starvation();
        if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0;
        for (int g = 0; g < 5; g++) begin
            d_addr = 32'h400 + 32'(g * 4); #1;
            n_chk++; if ({if_gnt, d_gnt} !== {g == 4, g != 4}) $display("FAIL starve_gnt%0d got=%b exp=%b", g, {if_gnt, d_gnt}, {g == 4, g != 4}); else n_pass++;
            if (g > 0) begin
                n_chk++; if (d_rvalid !== 1 || d_rdata !== exp_d_rdata) $display("FAIL starve_rv%0d got=%b/%h exp=1/%h", g, d_rvalid, d_rdata, exp_d_rdata); else n_pass++;
            end
            @(negedge clk);
            if (g == 4) begin if_req = 0; d_req = 0; end
            mem_ack = 1; mem_rdata = 32'hA000_0000 + 32'(g); #1;
            n_chk++; if (mem_addr !== ((g == 4) ? 32'h300 : 32'h400 + 32'(g * 4))) $display("FAIL starve_addr%0d got=%h", g, mem_addr); else n_pass++;
            @(negedge clk); mem_ack = 0;
            if (g < 4) exp_d_rdata = 32'hA000_0000 + 32'(g);
        end
        #1;
        n_chk++; if (if_rvalid !== 1 || if_rdata !== 32'hA000_0004) $display("FAIL starve_fetch_rv got=%b/%h exp=1/a0000004", if_rvalid, if_rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 32'h2002; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; #1;
        n_chk++; if (d_gnt !== 1) $display("FAIL st_gnt got=%b exp=1", d_gnt); else n_pass++;
        @(negedge clk); d_req = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3); mem_rdata = 32'hFFFF_FFFF; #1;
            n_chk++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF})
                $display("FAIL st_busy%0d got=%b/%b/%h/%h/%h", k, mem_req, mem_we, mem_be, mem_addr, mem_wdata); else n_pass++;
            @(negedge clk);
        end
        mem_ack = 0; d_we = 0; #1;
        n_chk++; if (d_rvalid !== 1 || d_rdata !== exp_d_rdata) $display("FAIL st_done got=%b/%h exp=1/%h", d_rvalid, d_rdata, exp_d_rdata); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (d_rvalid !== 0 || mem_req !== 0) $display("FAIL st_after got=%b/%b exp=0/0", d_rvalid, mem_req); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        d_req = 1; d_we = 0; d_addr = 32'h3000; #1;
        n_chk++; if (d_gnt !== 1) $display("FAIL ar_gnt got=%b exp=1", d_gnt); else n_pass++;
        @(negedge clk); d_req = 0; #1;
        n_chk++; if (mem_req !== 1) $display("FAIL ar_busy got=%b exp=1", mem_req); else n_pass++;
        #2 reset = 0; #1;
        n_chk++; if (mem_req !== 0 || mem_addr !== 0) $display("FAIL ar_drop got=%b/%h exp=0/0", mem_req, mem_addr); else n_pass++;
        @(negedge clk); reset = 1; mem_ack = 1; #1;
        n_chk++; if (d_rvalid !== 0) $display("FAIL ar_no_rv0 got=%b exp=0", d_rvalid); else n_pass++;
        @(negedge clk); mem_ack = 0; if_req = 1; if_addr = 32'h40; #1;
        exp_d_rdata = 32'h0;
        n_chk++; if (d_rvalid !== 0 || d_rdata !== 0 || if_gnt !== 1) $display("FAIL ar_release got=%b/%h/%b exp=0/0/1", d_rvalid, d_rdata, if_gnt); else n_pass++;
        @(negedge clk); if_req = 0; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk); mem_ack = 0; #1;
        n_chk++; if (if_rvalid !== 1 || if_rdata !== 32'h5555_AAAA) $display("FAIL ar_fetch got=%b/%h exp=1/5555aaaa", if_rvalid, if_rdata); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        if_req = 1; if_addr = 32'h500; mem_ack = 0;
        @(negedge clk); if_req = 0;
`ifdef ARB_TIMEOUT_EN
        cyc = 1;
        while (cyc < 30) begin
            #1; if (if_rvalid === 1) break;
            @(negedge clk); cyc++;
        end
        n_chk++; if (cyc !== 9) $display("FAIL to_latency got=%0d exp=9", cyc); else n_pass++;
        n_chk++; if (bus_err !== 1 || if_rdata !== 0 || mem_req !== 0) $display("FAIL to_abort got=%b/%h/%b exp=1/0/0", bus_err, if_rdata, mem_req); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (bus_err !== 0 || if_rvalid !== 0) $display("FAIL to_after got=%b/%b exp=0/0", bus_err, if_rvalid); else n_pass++;
        @(negedge clk);
`else
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            #1; if (mem_req === 1 && bus_err === 0 && if_rvalid === 0) cyc++;
            @(negedge clk);
        end
        n_chk++; if (cyc !== 20) $display("FAIL to_wait got=%0d exp=20", cyc); else n_pass++;
        reset = 0; @(negedge clk); reset = 1;
`endif
    endtask

    task automatic test_random();
        bit          if_p, d_p, dwe, ack_now, e_we;
        logic [31:0] ia, da, dw, rd, e_addr, e_wdata, e_ird, e_drd;
        logic [3:0]  dbe, e_be;
        int          starve, owner, winner, wait_left;
        bit          rv_if, rv_d;
        reset = 0; @(negedge clk); reset = 1;
        if_p = 0; d_p = 0; starve = 0; owner = 0; rv_if = 0; rv_d = 0; wait_left = 0;
        e_ird = 0; e_drd = 0; ia = 0; da = 0; dw = 0; dbe = 0; dwe = 0;
        e_addr = 0; e_wdata = 0; e_be = 0; e_we = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!if_p && $urandom_range(0, 2) != 0) begin if_p = 1; ia = $urandom; end
            if (!d_p && $urandom_range(0, 2) != 0) begin
                d_p = 1; da = $urandom; dw = $urandom; dbe = 4'($urandom); dwe = 1'($urandom);
            end
            if_req = if_p; if_addr = ia; d_req = d_p; d_addr = da; d_wdata = dw; d_be = dbe; d_we = dwe;
            ack_now = 0;
            if (owner != 0) begin
                if (wait_left == 0) ack_now = 1; else wait_left--;
                mem_ack = ack_now;
            end else begin
                mem_ack = 1'($urandom);
            end
            rd = $urandom; mem_rdata = rd;
            winner = (owner != 0) ? 0 : (if_p && (!d_p || starve == LIMIT)) ? 1 : d_p ? 2 : 0;
            #1;
            n_chk++; if ({if_rvalid, d_rvalid, bus_err, fetch_stall, mem_req} !== {rv_if, rv_d, 1'b0, if_p && !rv_if, owner != 0})
                $display("FAIL rnd_ctl c%0d got=%b exp=%b", cyc, {if_rvalid, d_rvalid, bus_err, fetch_stall, mem_req}, {rv_if, rv_d, 1'b0, if_p && !rv_if, owner != 0}); else n_pass++;
            n_chk++; if (if_rdata !== e_ird || d_rdata !== e_drd) $display("FAIL rnd_rdata c%0d got=%h/%h exp=%h/%h", cyc, if_rdata, d_rdata, e_ird, e_drd); else n_pass++;
            n_chk++; if ({if_gnt, d_gnt} !== {winner == 1, winner == 2}) $display("FAIL rnd_gnt c%0d got=%b exp=%b", cyc, {if_gnt, d_gnt}, {winner == 1, winner == 2}); else n_pass++;
            if (owner != 0) begin
                n_chk++; if (mem_addr !== e_addr || mem_we !== e_we || mem_be !== e_be || (e_we && mem_wdata !== e_wdata))
                    $display("FAIL rnd_mem c%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", cyc, mem_addr, mem_we, mem_be, mem_wdata, e_addr, e_we, e_be, e_wdata); else n_pass++;
            end
            rv_if = 0; rv_d = 0;
            if (owner != 0 && ack_now) begin
                if (owner == 1) begin rv_if = 1; e_ird = rd; end
                else begin rv_d = 1; if (!e_we) e_drd = rd; end
                owner = 0;
            end else if (winner == 1) begin
                owner = 1; starve = 0; if_p = 0;
                e_addr = {ia[31:2], 2'b00}; e_we = 0; e_be = 4'hF;
                wait_left = $urandom_range(0, 3);
            end else if (winner == 2) begin
                owner = 2; d_p = 0;
                if (if_p && starve < LIMIT) starve++;
                e_addr = {da[31:2], 2'b00}; e_we = dwe; e_be = dwe ? dbe : 4'hF; e_wdata = dw;
                wait_left = $urandom_range(0, 3);
            end
            @(negedge clk);
        end
        if_req = 0; d_req = 0; mem_ack = 0;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_async_reset();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Arbiter that shares one single-ported unified memory between the instruction fetch unit and the load/store stage of the MIPS core. It accepts one request at a time, drives the memory until the memory acknowledges, then returns read data or write completion to the winning requester. Data accesses win by default. A starvation counter forces a fetch grant after a bounded run of data grants, and the block raises fetch_stall so the PC holds while a fetch is outstanding.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before fetch is forced (1..15)
TIMEOUT_CYC, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request; held until if_gnt
if_addr  input  32  fetch byte address; bits [1:0] ignored
if_gnt  output  1  fetch request accepted (1-cycle pulse)
if_rvalid  output  1  fetch data valid (1-cycle pulse)
if_rdata  output  32  instruction word
fetch_stall  output  1  PC must hold this cycle
d_req  input  1  data request; held until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address; bits [1:0] ignored
d_wdata  input  32  store data
d_be  input  4  store byte enables
d_gnt  output  1  data request accepted (1-cycle pulse)
d_rvalid  output  1  load data valid / store done (1-cycle pulse)
d_rdata  output  32  load data
mem_req  output  1  memory access active
mem_we  output  1  memory write
mem_addr  output  32  word-aligned address, [1:0] = 2'b00
mem_wdata  output  32  write data
mem_be  output  4  byte enables, 4'hF for reads
mem_ack  input  1  memory completes the access this cycle
mem_rdata  input  32  read data, valid with mem_ack
bus_err  output  1  watchdog abort pulse (always 0 without ARB_TIMEOUT_EN)

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE with no request: stay in IDLE. All gnt/rvalid are 0 and mem_req is 0.
- IDLE with one or both requests: pick the winner combinationally in the same cycle.
  - Winner is fetch if if_req && (!d_req || starve_cnt == STARVE_LIMIT). Otherwise the winner is data.
  - Pulse the winner's gnt in that cycle. On the clock edge, register the address, we, wdata and be into the mem_* outputs, and move to BUSY_IF or BUSY_D.
- BUSY_*: mem_req = 1 and the mem_* outputs are stable. On mem_ack, capture mem_rdata into if_rdata or d_rdata and pulse if_rvalid or d_rvalid on the next cycle. In that same cycle the FSM returns to IDLE, so mem_req = 0.
- Minimum access is 3 cycles: grant, one or more busy cycles, rvalid/IDLE. Back-to-back accesses always have one idle-return cycle between them.
- A new arbitration may occur in the rvalid cycle.
- Fetch reads: mem_we = 0, mem_be = 4'hF. Data loads: mem_be = 4'hF. Data stores: mem_be = d_be. mem_addr = {addr[31:2], 2'b00}.
- d_rvalid pulses on store completion as well; d_rdata is undefined for stores and is held at its previous value.
- starve_cnt (4 bits):
  - Clears on every fetch grant.
  - Increments on each data grant while if_req = 1, saturating at STARVE_LIMIT.
  - Unchanged otherwise.
- fetch_stall = if_req && !if_rvalid.
- rdata registers hold their value until the next capture.
- Requests that deassert without a grant are a protocol violation; the block does not check for them.
- Reset (asynchronous, any state, including mid-access):
  - FSM goes to IDLE.
  - starve_cnt, all mem_* outputs, gnt, rvalid, rdata and bus_err go to 0.
  - mem_req drops immediately, and the in-flight access is discarded.
- mem_ack outside the BUSY states is ignored.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit watchdog counts cycles spent in BUSY_*.
  - When it reaches TIMEOUT_CYC without mem_ack, the FSM aborts to IDLE.
  - It pulses bus_err together with the owner's rvalid, with rdata = 32'h0.
  - The counter clears on entry to BUSY.
- Undefined: no watchdog; bus_err is tied to 0 and a BUSY state waits indefinitely.

Test Plan:
- Single fetch, if_addr=32'h0000_0104, mem_ack on 1st busy cycle, mem_rdata=32'h2408_0005 -> if_gnt in cycle 0; mem_addr=32'h104, mem_be=F in cycle 1; if_rvalid with if_rdata=32'h2408_0005 in cycle 2; fetch_stall 1 in cycles 0-1 and 0 in cycle 2.
- Simultaneous if_req and d_req (load from 32'h1003) with starve_cnt=0 -> d_gnt first, mem_addr=32'h1000; fetch granted in d_rvalid cycle; starve_cnt was 1 then clears.
- d_req held continuously with if_req pending, STARVE_LIMIT=4 -> four data grants, then the 5th grant goes to fetch; starve_cnt goes 1,2,3,4,0.
- Store d_be=4'b0011, d_wdata=32'hDEAD_BEEF, mem_ack after 3 wait cycles -> mem_we=1, mem_be=3 stable for 4 cycles; d_rvalid pulses once; d_rdata unchanged.
- reset low while BUSY_D with mem_req=1 -> mem_req=0 asynchronously; no d_rvalid after release; a fetch request after release is granted in its first cycle.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ack never asserted on a fetch -> bus_err and if_rvalid pulse together with if_rdata=0, then FSM is in IDLE.
